// File: rtl/alu_control.sv
// alu_control: decodes MIPS R-type function codes into per-unit control codes.
// Single-cycle classes (ALU, shift, move, illegal) complete one cycle after
// acceptance; MULTU holds the multiplier for MUL_CYCLES cycles and strobes
// hilo_we with done on its final cycle. All outputs are registered.
// Optional feature: define ALU_CONTROL_ILLEGAL_EN to add the 'illegal' output.
module alu_control #(
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] funct,
  output logic [5:0] SignaltoALU,
  output logic [5:0] SignaltoSHT,
  output logic [5:0] SignaltoMUL,
  output logic [5:0] SignaltoMUX,
  output logic       hilo_we,
  output logic       busy,
`ifdef ALU_CONTROL_ILLEGAL_EN
  output logic       done,
  output logic       illegal
`else
  output logic       done
`endif
);

  localparam logic [5:0] FnAnd   = 6'b100100;
  localparam logic [5:0] FnOr    = 6'b100101;
  localparam logic [5:0] FnAdd   = 6'b100000;
  localparam logic [5:0] FnSub   = 6'b100010;
  localparam logic [5:0] FnSlt   = 6'b101010;
  localparam logic [5:0] FnSrl   = 6'b000010;
  localparam logic [5:0] FnMfhi  = 6'b010000;
  localparam logic [5:0] FnMflo  = 6'b010010;
  localparam logic [5:0] FnMultu = 6'b011001;

  // Counter values for the final MUL cycle and the one before it; outputs are
  // registered, so the final-cycle strobes are computed one cycle early.
  localparam logic [5:0] CntLast = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] CntPen  = 6'(MUL_CYCLES - 2);

  typedef enum logic [1:0] {StIdle, StExec, StMul} state_e;

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] alu_q, alu_d;
  logic [5:0] sht_q, sht_d;
  logic [5:0] mul_q, mul_d;
  logic [5:0] mux_q, mux_d;
  logic       hilo_we_q, hilo_we_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
`ifdef ALU_CONTROL_ILLEGAL_EN
  logic       illegal_q, illegal_d;
`endif

  logic is_alu, is_sht, is_mov, is_mul;

  // Classify the requested function code.
  always_comb begin
    is_alu = (funct == FnAnd) || (funct == FnOr) || (funct == FnAdd) ||
             (funct == FnSub) || (funct == FnSlt);
    is_sht = (funct == FnSrl);
    is_mov = (funct == FnMfhi) || (funct == FnMflo);
    is_mul = (funct == FnMultu);
  end

  // State, counter and registered outputs; reset is asynchronous.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      alu_q     <= '0;
      sht_q     <= '0;
      mul_q     <= '0;
      mux_q     <= '0;
      hilo_we_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef ALU_CONTROL_ILLEGAL_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_q     <= alu_d;
      sht_q     <= sht_d;
      mul_q     <= mul_d;
      mux_q     <= mux_d;
      hilo_we_q <= hilo_we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef ALU_CONTROL_ILLEGAL_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // Next state and multiply cycle counter; requests are only taken in idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d   = '0;
          state_d = is_mul ? StMul : StExec;
        end
      end
      StExec: state_d = StIdle;
      StMul: begin
        if (cnt_q == CntLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs, i.e. what the next cycle shows.
  always_comb begin
    alu_d     = '0;
    sht_d     = '0;
    mul_d     = '0;
    mux_d     = mux_q;
    hilo_we_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
`ifdef ALU_CONTROL_ILLEGAL_EN
    illegal_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (is_alu) begin
            alu_d  = funct;
            mux_d  = funct;
            done_d = 1'b1;
          end else if (is_sht) begin
            sht_d  = funct;
            mux_d  = funct;
            done_d = 1'b1;
          end else if (is_mov) begin
            mux_d  = funct;
            done_d = 1'b1;
          end else if (is_mul) begin
            mul_d  = FnMultu;
            busy_d = 1'b1;
          end else begin
            // Illegal code: complete immediately, leave the MUX select alone.
            done_d = 1'b1;
`ifdef ALU_CONTROL_ILLEGAL_EN
            illegal_d = 1'b1;
`endif
          end
        end
      end
      StExec: ;
      StMul: begin
        if (cnt_q != CntLast) begin
          mul_d     = FnMultu;
          busy_d    = 1'b1;
          hilo_we_d = (cnt_q == CntPen);
          done_d    = (cnt_q == CntPen);
        end
      end
      default: ;
    endcase
  end

  assign SignaltoALU = alu_q;
  assign SignaltoSHT = sht_q;
  assign SignaltoMUL = mul_q;
  assign SignaltoMUX = mux_q;
  assign hilo_we     = hilo_we_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef ALU_CONTROL_ILLEGAL_EN
  assign illegal     = illegal_q;
`endif

endmodule

// File: tb/tb_alu_control.sv
// tb_alu_control: directed vectors for alu_control. Stimulus pushes the
// expected output snapshot for every completing request into a queue; a
// monitor pops and compares whenever done is high.
module tb_alu_control;

  localparam logic [5:0] FnAnd   = 6'b100100;
  localparam logic [5:0] FnOr    = 6'b100101;
  localparam logic [5:0] FnAdd   = 6'b100000;
  localparam logic [5:0] FnSub   = 6'b100010;
  localparam logic [5:0] FnSlt   = 6'b101010;
  localparam logic [5:0] FnSrl   = 6'b000010;
  localparam logic [5:0] FnMfhi  = 6'b010000;
  localparam logic [5:0] FnMflo  = 6'b010010;
  localparam logic [5:0] FnMultu = 6'b011001;
  localparam logic [5:0] FnBad   = 6'b111111;
  localparam logic [5:0] Zero6   = 6'b000000;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] funct;
  logic [5:0] SignaltoALU, SignaltoSHT, SignaltoMUL, SignaltoMUX;
  logic       hilo_we, busy, done;
  logic       ill;

`ifdef ALU_CONTROL_ILLEGAL_EN
  localparam logic IllExp = 1'b1;
  logic illegal;
  assign ill = illegal;
`else
  localparam logic IllExp = 1'b0;
  assign ill = 1'b0;
`endif

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [31:0] sb[$];
  logic [31:0] act;

  assign act = {5'd0, SignaltoALU, SignaltoSHT, SignaltoMUL, SignaltoMUX, hilo_we, busy, ill};

  alu_control #(
    .MUL_CYCLES(32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .funct      (funct),
    .SignaltoALU(SignaltoALU),
    .SignaltoSHT(SignaltoSHT),
    .SignaltoMUL(SignaltoMUL),
    .SignaltoMUX(SignaltoMUX),
    .hilo_we    (hilo_we),
    .busy       (busy),
`ifdef ALU_CONTROL_ILLEGAL_EN
    .done       (done),
    .illegal    (illegal)
`else
    .done       (done)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input logic [5:0] a, input logic [5:0] s,
                                     input logic [5:0] m, input logic [5:0] x,
                                     input logic h, input logic b, input logic i);
    return {5'd0, a, s, m, x, h, b, i};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Accept a request at the next rising edge; optionally expect a completion.
  task automatic issue(input logic [5:0] f, input bit exp_done, input logic [31:0] e);
    @(negedge clk);
    if (exp_done) sb.push_back(e);
    start = 1'b1;
    funct = f;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait until every expected completion has been seen and the DUT is idle.
  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_within_budget", 32'(n < 100), 32'd1);
    @(negedge clk);
  endtask

  // Monitor: compare the output snapshot on every completion.
  initial begin
    forever begin
      @(negedge clk);
      if (hilo_we) check("hilo_we_only_with_done", 32'(done), 32'd1);
      if (done) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got outputs %h, required no completion", act);
        end else begin
          check("done_outputs", act, sb.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic [5:0] ops[5];
    logic [5:0] exp_mux;
    int cnt;
    int done_idx;
    int bad_mul;

    ops[0] = FnAnd;
    ops[1] = FnOr;
    ops[2] = FnSub;
    ops[3] = FnSlt;
    ops[4] = FnMfhi;

    reset = 1'b1;
    start = 1'b0;
    funct = Zero6;
    exp_mux = Zero6;
    repeat (2) @(negedge clk);
    check("reset_signals", act, pk(Zero6, Zero6, Zero6, Zero6, 1'b0, 1'b0, 1'b0));
    check("reset_done", 32'(done), 32'd0);
    reset = 1'b0;

    // ADD: done one cycle after acceptance, ALU code gone the cycle after.
    exp_mux = FnAdd;
    issue(FnAdd, 1'b1, pk(FnAdd, Zero6, Zero6, FnAdd, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    @(negedge clk);
    check("add_n2_alu", 32'(SignaltoALU), 32'd0);
    check("add_n2_done", 32'(done), 32'd0);
    check("add_n2_mux_held", 32'(SignaltoMUX), 32'(FnAdd));

    // Remaining ALU codes and MFHI.
    for (int i = 0; i < 5; i++) begin
      exp_mux = ops[i];
      issue(ops[i], 1'b1, pk((i < 4) ? ops[i] : Zero6, Zero6, Zero6, ops[i], 1'b0, 1'b0, 1'b0));
      wait_drain();
    end

    // SRL then MFLO; the MUX select must hold afterwards.
    exp_mux = FnSrl;
    issue(FnSrl, 1'b1, pk(Zero6, FnSrl, Zero6, FnSrl, 1'b0, 1'b0, 1'b0));
    wait_drain();
    exp_mux = FnMflo;
    issue(FnMflo, 1'b1, pk(Zero6, Zero6, Zero6, FnMflo, 1'b0, 1'b0, 1'b0));
    wait_drain();
    repeat (5) @(negedge clk);
    check("mflo_mux_held", 32'(SignaltoMUX), 32'(FnMflo));
    check("idle_sht_zero", 32'(SignaltoSHT), 32'd0);

    // Start held into the done cycle is ignored.
    @(negedge clk);
    sb.push_back(pk(FnOr, Zero6, Zero6, FnOr, 1'b0, 1'b0, 1'b0));
    start = 1'b1;
    funct = FnOr;
    @(posedge clk);
    #1;
    funct = FnSub;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_mux = FnOr;
    @(negedge clk);
    check("start_in_done_cycle_done", 32'(done), 32'd0);
    check("start_in_done_cycle_mux", 32'(SignaltoMUX), 32'(FnOr));
    wait_drain();

    // MULTU: 32 busy cycles, done/hilo_we in the last; AND at cycle 10 ignored.
    issue(FnMultu, 1'b1, pk(Zero6, Zero6, FnMultu, exp_mux, 1'b1, 1'b1, 1'b0));
    cnt = 0;
    done_idx = 0;
    bad_mul = 0;
    while (cnt < 100) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if (done) done_idx = cnt;
      if (SignaltoMUL !== FnMultu) bad_mul++;
      if (cnt == 10) begin
        start = 1'b1;
        funct = FnAnd;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("mul_busy_cycles", 32'(cnt), 32'd32);
    check("mul_done_cycle", 32'(done_idx), 32'd32);
    check("mul_code_while_busy", 32'(bad_mul), 32'd0);
    check("mul_after_code", 32'(SignaltoMUL), 32'd0);
    check("mul_after_mux", 32'(SignaltoMUX), 32'(exp_mux));
    wait_drain();

    // Asynchronous reset mid-multiply clears everything before any clock edge.
    issue(FnMultu, 1'b0, 32'd0);
    repeat (15) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_signals", act, pk(Zero6, Zero6, Zero6, Zero6, 1'b0, 1'b0, 1'b0));
    check("async_reset_done", 32'(done), 32'd0);
    exp_mux = Zero6;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("aborted_mul_idle", 32'(busy), 32'd0);

    exp_mux = FnAdd;
    issue(FnAdd, 1'b1, pk(FnAdd, Zero6, Zero6, FnAdd, 1'b0, 1'b0, 1'b0));
    wait_drain();

    // Illegal code: completes, MUX select unchanged.
    issue(FnBad, 1'b1, pk(Zero6, Zero6, Zero6, exp_mux, 1'b0, 1'b0, IllExp));
    wait_drain();
    check("illegal_after_done", 32'(done), 32'd0);
    check("illegal_mux_held", 32'(SignaltoMUX), 32'(FnAdd));

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_control.md
ALU_CONTROL -- requirements
Module: alu_control

Interface
REQ-001 Parameter MUL_CYCLES, default 32, sets the number of cycles a MULTU occupies the multiplier; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request strobe; funct is sampled on the clk edge where start=1 and busy=0.
REQ-005 funct  input  6  MIPS R-type function code of the requested operation.
REQ-006 SignaltoALU  output  6  function code to the ALU.
REQ-007 SignaltoSHT  output  6  function code to the shifter.
REQ-008 SignaltoMUL  output  6  function code to the multiplier.
REQ-009 SignaltoMUX  output  6  select code to the result MUX; bit5=ALU, bit4=Hi/Lo (bit1 chooses Lo), else shifter.
REQ-010 hilo_we  output  1  one-cycle write strobe to the Hi/Lo register.
REQ-011 busy  output  1  high while a multi-cycle operation is in progress.
REQ-012 done  output  1  one-cycle pulse marking operation completion.

Function
REQ-013 Codes: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010 (ALU class); SRL 000010 (shift class); MFHI 010000, MFLO 010010 (move class); MULTU 011001 (multiply class); any other value is illegal.
REQ-014 FSM states IDLE, EXEC, MUL, with all outputs registered.
REQ-015 IDLE + accepted start of ALU, shift, move or illegal class -> EXEC; MULTU -> MUL with cycle counter cleared to 0.
REQ-016 EXEC lasts exactly one cycle, asserts done=1, then returns to IDLE.
REQ-017 In EXEC: ALU class drives SignaltoALU=funct; shift class drives SignaltoSHT=funct; other signal outputs are 0 that cycle.
REQ-018 SignaltoMUX is loaded with funct on acceptance of ALU, shift or move class, and holds that value until the next such acceptance; MULTU and illegal codes leave it unchanged.
REQ-019 Latency: start accepted at edge N -> done high in cycle N+1 for single-cycle classes.
REQ-020 In MUL: SignaltoMUL=011001 and busy=1 for MUL_CYCLES consecutive cycles (N+1..N+MUL_CYCLES); counter increments each cycle.
REQ-021 On the last MUL cycle (counter = MUL_CYCLES-1), hilo_we=1 and done=1 in the same cycle; next state IDLE, SignaltoMUL returns to 0.
REQ-022 start while busy=1 is ignored; no queuing; funct changes during MUL have no effect.
REQ-023 start asserted in the cycle done=1 (state EXEC or last MUL cycle) is ignored; a new request is accepted only from IDLE.
REQ-024 Illegal funct: done=1 for one cycle, all signal outputs 0, hilo_we=0, SignaltoMUX unchanged.
REQ-025 SignaltoALU, SignaltoSHT and SignaltoMUL are 0 whenever the state is IDLE.

Reset
REQ-026 reset=1 forces IDLE immediately, without waiting for clk.
REQ-027 Reset values: all Signalto* = 000000, hilo_we=0, busy=0, done=0, counter=0.
REQ-028 Reset during MUL aborts the operation; hilo_we is not asserted for the aborted multiply.

Configuration
REQ-029 Macro ALU_CONTROL_ILLEGAL_EN: when defined, adds output port illegal (1 bit, reset 0), pulsed high together with done for an illegal funct and 0 otherwise.
REQ-030 Without ALU_CONTROL_ILLEGAL_EN: port illegal does not exist; illegal funct behaves exactly as REQ-024.

Verification
REQ-031 Reset, start=1 funct=100000 at edge N -> cycle N+1: SignaltoALU=100000, SignaltoMUX=100000, done=1; cycle N+2: SignaltoALU=0, done=0.
REQ-032 start funct=000010, then after it completes start funct=010010 -> SignaltoSHT=000010 then SignaltoMUX=010010 held with no further starts.
REQ-033 start funct=011001 (MUL_CYCLES=32) -> busy=1 and SignaltoMUL=011001 for exactly 32 cycles; hilo_we=1 and done=1 only in the 32nd; start=1 funct=100100 at cycle 10 is ignored.
REQ-034 start MULTU, assert reset asynchronously mid-cycle at cycle 15 -> all outputs 0 immediately; hilo_we never pulses; next start ADD accepted normally.
REQ-035 start funct=111111 -> done=1 for one cycle, all Signalto* unchanged/0; with ALU_CONTROL_ILLEGAL_EN defined, illegal=1 in that same cycle.
